// File: rtl/vadd_sws.sv
`default_nettype none
// ============================================================================
// Module   : vadd_sws
// Purpose  : Single-word signed saturating adder (AltiVec vaddsws word lane).
//            Adds two 32-bit two's-complement operands, clamps the sum to the
//            signed 32-bit range and registers the result in one cycle. A
//            per-result saturation flag and a sticky saturation flag (a model
//            of VSCR[SAT]) are produced alongside the sum.
//
// Ports    :
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   in_valid    in   1   operands valid this cycle
//   vra         in  32   operand A, signed
//   vrb         in  32   operand B, signed
//   sat_clr     in   1   synchronous clear of the sticky saturation flag
//   out_valid   out  1   vrt/sat valid (in_valid delayed one cycle)
//   vrt         out 32   saturated sum, registered
//   sat         out  1   saturation occurred for the current vrt
//   sat_sticky  out  1   OR of all sat events since reset / last clear
//
// Revision : 1.0  initial release
// ============================================================================
module vadd_sws (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] vra,
  input  logic [31:0] vrb,
  input  logic        sat_clr,
  output logic        out_valid,
  output logic [31:0] vrt,
  output logic        sat,
  output logic        sat_sticky
);

  localparam logic [31:0] C_SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] C_SAT_NEG = 32'h8000_0000;

  // Registered state
  logic        out_valid_q, out_valid_d;
  logic [31:0] vrt_q,       vrt_d;
  logic        sat_q,       sat_d;
  logic        sat_sticky_q, sat_sticky_d;

  // Combinational datapath
  logic [32:0] sum_w;
  logic        pos_ovf_w;
  logic        neg_ovf_w;
  logic        sat_w;
  logic [31:0] res_w;

  // --------------------------------------------------------------------------
  // Saturating add. Overflow is only possible when both operands share a sign
  // and the low 32 bits of the sign-extended sum disagree with that sign.
  // --------------------------------------------------------------------------
  always_comb begin
    sum_w     = {vra[31], vra} + {vrb[31], vrb};
    pos_ovf_w = ~vra[31] & ~vrb[31] &  sum_w[31];
    neg_ovf_w =  vra[31] &  vrb[31] & ~sum_w[31];
    sat_w     = pos_ovf_w | neg_ovf_w;
    if (pos_ovf_w) begin
      res_w = C_SAT_POS;
    end else if (neg_ovf_w) begin
      res_w = C_SAT_NEG;
    end else begin
      res_w = sum_w[31:0];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Result registers hold when no operation is presented.
  // The sticky flag is cleared first and then set, so a saturating operation
  // in the same cycle as sat_clr leaves the flag set.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = in_valid;
    vrt_d        = vrt_q;
    sat_d        = sat_q;
    sat_sticky_d = sat_sticky_q;

    if (in_valid) begin
      vrt_d = res_w;
      sat_d = sat_w;
    end

    if (sat_clr) begin
      sat_sticky_d = 1'b0;
    end
    if (in_valid && sat_w) begin
      sat_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      vrt_q        <= 32'h0;
      sat_q        <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      vrt_q        <= vrt_d;
      sat_q        <= sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign vrt        = vrt_q;
  assign sat        = sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_vadd_sws.sv
`default_nettype none
// ============================================================================
// Module   : tb_vadd_sws
// Purpose  : Self-checking bench for vadd_sws. Directed vector table, a few
//            hand-written multi-cycle sequences (idle hold, sticky clear,
//            back-to-back stream, asynchronous reset) and a randomized run
//            checked against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vadd_sws;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] vra;
  logic [31:0] vrb;
  logic        sat_clr;
  logic        out_valid;
  logic [31:0] vrt;
  logic        sat;
  logic        sat_sticky;

  int errors = 0;
  int checks = 0;

  // Reference model state (what the outputs should currently show)
  logic [31:0] m_vrt;
  logic        m_sat;
  logic        m_ov;
  logic        m_sticky;

  vadd_sws dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .vra        (vra),
    .vrb        (vrb),
    .sat_clr    (sat_clr),
    .out_valid  (out_valid),
    .vrt        (vrt),
    .sat        (sat),
    .sat_sticky (sat_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        clr;
    logic [31:0] exp_vrt;
    logic        exp_sat;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs[12];

  // Saturating add by plain integer arithmetic: {sat, result}
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    else                           return {1'b0, s[31:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"},  {31'h0, out_valid},  {31'h0, m_ov});
    chk({tag, ".vrt"},        vrt,                 m_vrt);
    chk({tag, ".sat"},        {31'h0, sat},        {31'h0, m_sat});
    chk({tag, ".sat_sticky"}, {31'h0, sat_sticky}, {31'h0, m_sticky});
  endtask

  // Present one cycle of stimulus, advance the model across the edge and
  // sample the DUT 1 ns after the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic clr);
    logic [32:0] r;
    @(negedge clk);
    in_valid = v;
    vra      = a;
    vrb      = b;
    sat_clr  = clr;
    @(posedge clk);
    r    = ref_add(a, b);
    m_ov = v;
    if (v) begin
      m_vrt = r[31:0];
      m_sat = r[32];
    end
    if (clr)        m_sticky = 1'b0;
    if (v && r[32]) m_sticky = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    m_vrt = 32'h0; m_sat = 1'b0; m_ov = 1'b0; m_sticky = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; vra = '0; vrb = '0; sat_clr = 1'b0;
    model_reset();

    vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[1]  = '{32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[5]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0003, 1'b0, 1'b0};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[10] = '{32'hC000_0000, 32'hC000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0};
    vecs[11] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

    // Reset state, while reset is held
    #2;
    chk("reset.vrt",        vrt,                  32'h0);
    chk("reset.flags",      {29'h0, out_valid, sat, sat_sticky}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].clr);
      chk($sformatf("vec%0d.out_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("vec%0d.vrt", i), vrt, vecs[i].exp_vrt);
      chk($sformatf("vec%0d.sat", i), {31'h0, sat}, {31'h0, vecs[i].exp_sat});
      chk($sformatf("vec%0d.sticky", i), {31'h0, sat_sticky}, {31'h0, vecs[i].exp_sticky});
    end

    // Idle cycle: result and sat hold, out_valid drops, sticky holds (=1)
    step(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    chk("idle.out_valid", {31'h0, out_valid}, 32'h0);
    chk("idle.vrt",       vrt,                32'h7FFF_FFFF);
    chk("idle.sat",       {31'h0, sat},       32'h1);
    chk("idle.sticky",    {31'h0, sat_sticky}, 32'h1);

    // sat_clr with no operation clears the sticky flag only
    step(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    chk("clr_idle.sticky", {31'h0, sat_sticky}, 32'h0);
    chk("clr_idle.sat",    {31'h0, sat},        32'h1);
    chk("clr_idle.vrt",    vrt,                 32'h7FFF_FFFF);

    // Back-to-back stream of four operations
    step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    chk("b2b0.vrt", vrt, 32'h0000_0030);
    step(1'b1, 32'h7FFF_FFF0, 32'h0000_0100, 1'b0);
    chk("b2b1.vrt", vrt, 32'h7FFF_FFFF);
    chk("b2b1.sat", {31'h0, sat}, 32'h1);
    step(1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);
    chk("b2b2.vrt", vrt, 32'h0000_0000);
    chk("b2b2.sat", {31'h0, sat}, 32'h0);
    step(1'b1, 32'h8000_0001, 32'hFFFF_FFFE, 1'b0);
    chk("b2b3.vrt", vrt, 32'h8000_0000);
    chk_model("b2b3");

    // Asynchronous reset mid-stream, between edges, with an op in flight
    @(negedge clk);
    in_valid = 1'b1; vra = 32'h7FFF_FFFF; vrb = 32'h7FFF_FFFF; sat_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.vrt",   vrt, 32'h0);
    chk("async_rst.flags", {29'h0, out_valid, sat, sat_sticky}, 32'h0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.idle", {29'h0, out_valid, sat, sat_sticky}, 32'h0);
    step(1'b1, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0);
    chk("post_rst.vrt",       vrt, 32'h0);
    chk("post_rst.flags",     {29'h0, out_valid, sat, sat_sticky}, 32'h4);
    chk_model("post_rst");

    // Randomized run against the reference model, biased toward corners
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      logic v, c;
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF - $urandom_range(0, 3);
        1: a = 32'h8000_0000 + $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 3);
        1: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0);
      step(v, a, b, c);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
